// File: rtl/sb_stream_unpacker_if.sv
// Stream and control bundle for sb_stream_unpacker: packed words in,
// extended P-bit values out, plus the per-stream configuration pulse.
interface sb_stream_unpacker_if #(
  parameter int N  = 16,
  parameter int PW = 5
);
  logic          i_start;
  logic [PW-1:0] i_prec;
  logic          i_sext;
  logic          i_valid;
  logic [N-1:0]  i_data;
  logic          i_last;
  logic          o_ready;
  logic          o_valid;
  logic [N-1:0]  o_data;
  logic          i_ready;
  logic          o_done;

  modport master (
    output i_start, i_prec, i_sext, i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_done
  );

  modport slave (
    input  i_start, i_prec, i_sext, i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_done
  );
endinterface

// File: rtl/sb_stream_unpacker.sv
// Unpacks LSB-first P-bit values straddling N-bit words into one extended
// N-bit value per output handshake, using a 2N-bit shift buffer.
module sb_stream_unpacker #(
  parameter int N  = 16,
  parameter int PW = 5,
  parameter int CW = 6
) (
  input logic clk,
  input logic rst,
  sb_stream_unpacker_if.slave s
);
  localparam logic [CW-1:0] N_C = CW'(N);
  localparam logic [PW-1:0] N_P = PW'(N);

  logic [2*N-1:0] buf_q, buf_sh, buf_n;
  logic [CW-1:0]  cnt_q, cnt_sh, cnt_n, prec_c;
  logic [PW-1:0]  prec_q, prec_in;
  logic           sext_q, last_q, last_n, done_q, done_n;
  logic           push, pop;
  logic [N-1:0]   lo, sgn_v, data;
  logic           sgn;

  assign prec_c  = CW'(prec_q);
  assign prec_in = (s.i_prec == '0 || s.i_prec > N_P) ? N_P : s.i_prec;

  assign s.o_ready = !rst && !s.i_start && !last_q && (cnt_q <= N_C);
  assign s.o_valid = !rst && (cnt_q >= prec_c);
  assign s.o_done  = done_q;

  assign pop  = s.o_valid && s.i_ready;
  assign push = s.i_valid && s.o_ready;

  // Pop first so a same-cycle push lands right after the surviving bits.
  always_comb begin
    buf_sh = pop ? (buf_q >> prec_q) : buf_q;
    cnt_sh = pop ? (cnt_q - prec_c) : cnt_q;
    buf_n  = buf_sh;
    cnt_n  = cnt_sh;
    last_n = last_q;
    done_n = 1'b0;
    if (push) begin
      buf_n  = buf_sh | ({{N{1'b0}}, s.i_data} << cnt_sh);
      cnt_n  = cnt_sh + N_C;
      last_n = last_q | s.i_last;
    end
    if (last_q && (cnt_n < prec_c)) begin
      buf_n  = '0;
      cnt_n  = '0;
      last_n = 1'b0;
      done_n = 1'b1;
    end
  end

  // Bits at and above P come from the extension bit, not the buffer.
  always_comb begin
    lo    = buf_q[N-1:0];
    sgn_v = lo >> (prec_q - 1'b1);
    sgn   = sext_q & sgn_v[0];
    data  = '0;
    for (int i = 0; i < N; i++)
      data[i] = (i < int'(prec_q)) ? lo[i] : sgn;
  end
  assign s.o_data = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      prec_q <= N_P;
      sext_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else if (s.i_start) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      prec_q <= prec_in;
      sext_q <= s.i_sext;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      buf_q  <= buf_n;
      cnt_q  <= cnt_n;
      last_q <= last_n;
      done_q <= done_n;
    end
  end
endmodule

// File: tb/tb_sb_stream_unpacker.sv
// Directed bench for sb_stream_unpacker with hand-computed expected values.
module tb_sb_stream_unpacker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  sb_stream_unpacker_if #(.N(16), .PW(5)) bus ();
  sb_stream_unpacker #(.N(16), .PW(5), .CW(6)) dut (.clk(clk), .rst(rst), .s(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic start(input logic [4:0] p, input logic sx);
    bus.i_start = 1'b1; bus.i_prec = p; bus.i_sext = sx;
    samp();
    chk("start_rdy", {31'd0, bus.o_ready}, 32'd0);
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    bit ok = 0;
    bus.i_valid = 1'b1; bus.i_data = d; bus.i_last = last;
    for (int k = 0; k < 20; k++) begin
      samp();
      if (bus.o_ready) begin ok = 1; tick(); break; end
      tick();
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
    bus.i_valid = 1'b0; bus.i_last = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [15:0] exp);
    bit ok = 0;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      samp();
      if (bus.o_valid) begin chk(tag, {16'd0, bus.o_data}, {16'd0, exp}); ok = 1; tick(); break; end
      tick();
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [15:0] w4 [8] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8001,
                          16'hA5A5, 16'h5A5A, 16'hBEEF, 16'h0F0F};
  logic [15:0] t3 [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000};

  initial begin
    bus.i_start = 0; bus.i_prec = 0; bus.i_sext = 0; bus.i_valid = 0;
    bus.i_data = 0;  bus.i_last = 0; bus.i_ready = 0;

    // reset state
    samp();
    chk("rst_rdy", {31'd0, bus.o_ready}, 32'd0);
    chk("rst_vld", {31'd0, bus.o_valid}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    samp();
    chk("rel_rdy",  {31'd0, bus.o_ready}, 32'd1);
    chk("rel_vld",  {31'd0, bus.o_valid}, 32'd0);
    chk("rel_done", {31'd0, bus.o_done}, 32'd0);
    chk("rel_cnt",  {26'd0, dut.cnt_q}, 32'd0);
    tick();

    // P=4 zero-extend, one-cycle latency, back-to-back nibbles
    start(5'd4, 1'b0);
    bus.i_valid = 1; bus.i_data = 16'h4321;
    samp();
    chk("t1_rdy", {31'd0, bus.o_ready}, 32'd1);
    chk("t1_vld0", {31'd0, bus.o_valid}, 32'd0);
    tick();
    bus.i_valid = 0; bus.i_ready = 1;
    for (int k = 0; k < 4; k++) begin
      samp();
      chk("t1_vld", {31'd0, bus.o_valid}, 32'd1);
      chk("t1_dat", {16'd0, bus.o_data}, k + 1);
      tick();
    end
    samp();
    chk("t1_cnt", {26'd0, dut.cnt_q}, 32'd0);
    chk("t1_vldend", {31'd0, bus.o_valid}, 32'd0);
    tick();
    bus.i_ready = 0;

    // P=4 sign-extend
    start(5'd4, 1'b1);
    push(16'h00F8, 0);
    pop("t2_0", 16'hFFF8);
    pop("t2_1", 16'hFFFF);
    pop("t2_2", 16'h0000);
    pop("t2_3", 16'h0000);
    bus.i_ready = 0;

    // P=5 straddling values, i_last, residual drop, done pulse
    start(5'd5, 1'b0);
    push(16'h8421, 0);
    push(16'h0000, 1);
    samp();
    chk("t3_cnt", {26'd0, dut.cnt_q}, 32'd32);
    tick();
    bus.i_ready = 1;
    for (int k = 0; k < 6; k++) begin
      samp();
      chk("t3_vld", {31'd0, bus.o_valid}, 32'd1);
      chk("t3_dat", {16'd0, bus.o_data}, {16'd0, t3[k]});
      chk("t3_rdy", {31'd0, bus.o_ready}, 32'd0);
      chk("t3_done0", {31'd0, bus.o_done}, 32'd0);
      tick();
    end
    samp();
    chk("t3_done", {31'd0, bus.o_done}, 32'd1);
    chk("t3_vldend", {31'd0, bus.o_valid}, 32'd0);
    chk("t3_cntend", {26'd0, dut.cnt_q}, 32'd0);
    tick();
    samp();
    chk("t3_done1", {31'd0, bus.o_done}, 32'd0);
    tick();
    bus.i_ready = 0;

    // P=16 full throughput
    start(5'd16, 1'b0);
    bus.i_ready = 1; bus.i_valid = 1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) bus.i_data = w4[k]; else bus.i_valid = 0;
      samp();
      if (k < 8) chk("t4_rdy", {31'd0, bus.o_ready}, 32'd1);
      if (k > 0) begin
        chk("t4_vld", {31'd0, bus.o_valid}, 32'd1);
        chk("t4_dat", {16'd0, bus.o_data}, {16'd0, w4[k-1]});
      end else chk("t4_vld0", {31'd0, bus.o_valid}, 32'd0);
      tick();
    end
    samp();
    chk("t4_vldend", {31'd0, bus.o_valid}, 32'd0);
    tick();
    bus.i_ready = 0;

    // P=4 backpressure: buffer fills to 2N then o_ready drops
    start(5'd4, 1'b0);
    push(16'h3210, 0);
    push(16'h7654, 0);
    bus.i_valid = 1; bus.i_data = 16'hDEAD;
    samp();
    chk("t5_full_rdy", {31'd0, bus.o_ready}, 32'd0);
    chk("t5_full_cnt", {26'd0, dut.cnt_q}, 32'd32);
    tick();
    samp();
    chk("t5_hold_rdy", {31'd0, bus.o_ready}, 32'd0);
    tick();
    bus.i_valid = 0; bus.i_ready = 1;
    for (int k = 0; k < 8; k++) begin
      samp();
      chk("t5_rdy", {31'd0, bus.o_ready}, (k >= 4) ? 32'd1 : 32'd0);
      chk("t5_vld", {31'd0, bus.o_valid}, 32'd1);
      chk("t5_dat", {16'd0, bus.o_data}, k);
      tick();
    end
    bus.i_ready = 0;

    // mid-stream i_start flushes and switches precision
    start(5'd3, 1'b0);
    push(16'h0FFF, 0);
    pop("t6_p3", 16'h0007);
    bus.i_ready = 0;
    bus.i_start = 1; bus.i_prec = 5'd4; bus.i_valid = 1; bus.i_data = 16'h1111; bus.i_ready = 1;
    samp();
    chk("t6_start_rdy", {31'd0, bus.o_ready}, 32'd0);
    tick();
    bus.i_start = 0; bus.i_valid = 0; bus.i_ready = 0;
    samp();
    chk("t6_cnt", {26'd0, dut.cnt_q}, 32'd0);
    chk("t6_vld", {31'd0, bus.o_valid}, 32'd0);
    tick();
    push(16'h00A5, 0);
    pop("t6_n0", 16'h0005);
    pop("t6_n1", 16'h000A);
    bus.i_ready = 0;

    // precision 0 is treated as N
    start(5'd0, 1'b1);
    push(16'hBEEF, 0);
    pop("t7_p0", 16'hBEEF);
    bus.i_ready = 0;

    // mid-stream reset
    start(5'd4, 1'b0);
    push(16'h1234, 0);
    rst = 1; bus.i_valid = 1; bus.i_ready = 1;
    samp();
    chk("t8_rst_vld", {31'd0, bus.o_valid}, 32'd0);
    chk("t8_rst_rdy", {31'd0, bus.o_ready}, 32'd0);
    tick();
    samp();
    chk("t8_rst_vld2", {31'd0, bus.o_valid}, 32'd0);
    tick();
    rst = 0; bus.i_valid = 0; bus.i_ready = 0;
    samp();
    chk("t8_cnt", {26'd0, dut.cnt_q}, 32'd0);
    chk("t8_vld", {31'd0, bus.o_valid}, 32'd0);
    chk("t8_rdy", {31'd0, bus.o_ready}, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
